// File: rtl/gp_timer_pkg.sv
// gp_timer_pkg
// Shared encodings for the multi-channel timer: channel modes, edge-select
// codes, per-channel register indices and bit positions inside CTRL, STATUS
// and CMD. Imported by gp_timer_channel and gp_timer_array.
package gp_timer_pkg;

    typedef enum logic [1:0] {
        MODE_TIMER   = 2'd0,
        MODE_PWM     = 2'd1,
        MODE_EVENT   = 2'd2,
        MODE_CAPTURE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        EDGE_SW   = 2'd0,  // only CMD.SW_TRIG produces events
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2,
        EDGE_BOTH = 2'd3
    } edge_e;

    // Register index inside a channel window (addr_i[2:0])
    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_PRESC   = 3'd1;
    localparam logic [2:0] REG_TARGET  = 3'd2;
    localparam logic [2:0] REG_COMPARE = 3'd3;
    localparam logic [2:0] REG_COUNT   = 3'd4;
    localparam logic [2:0] REG_CAPTURE = 3'd5;
    localparam logic [2:0] REG_STATUS  = 3'd6;
    localparam logic [2:0] REG_CMD     = 3'd7;

    // CTRL bit positions
    localparam int CTRL_EN        = 0;
    localparam int CTRL_MODE_LSB  = 1;
    localparam int CTRL_INV       = 3;
    localparam int CTRL_ONESHOT   = 4;
    localparam int CTRL_EDGE_LSB  = 5;
    localparam int CTRL_IE_WRAP   = 7;
    localparam int CTRL_IE_CAP    = 8;
    localparam int CTRL_INSEL_LSB = 12;

    // Writable CTRL fields; bits [11:9] always read back as 0
    localparam logic [15:0] CTRL_MASK = 16'hF1FF;

    // STATUS bit positions
    localparam int STAT_WRAP = 0;
    localparam int STAT_CAP  = 1;
    localparam int STAT_OVR  = 2;
    localparam int STAT_RUN  = 3;

    // CMD bit positions
    localparam int CMD_CLEAR  = 0;
    localparam int CMD_SWTRIG = 1;

endpackage

// File: rtl/gp_timer_channel.sv
// gp_timer_channel
// One timer channel: configuration registers, prescaler, counter, mode logic
// (timer / PWM / event counter / input capture), W1C status flags and the
// registered channel output.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   wr_i            write strobe for this channel (already decoded)
//   reg_i           register index for the current access
//   wdata_i         bus write data
//   rise_i, fall_i  synchronised single-cycle edge pulses of all inputs
//   rdata_o         combinational read data for reg_i
//   out_o           registered timer / PWM output
//   irq_req_o       this channel's enabled pending flags
module gp_timer_channel
    import gp_timer_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 8,
    parameter int NUM_IN  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_i,
    input  logic [2:0]        reg_i,
    input  logic [15:0]       wdata_i,
    input  logic [NUM_IN-1:0] rise_i,
    input  logic [NUM_IN-1:0] fall_i,
    output logic [15:0]       rdata_o,
    output logic              out_o,
    output logic              irq_req_o
);

    logic [15:0]        ctrl_q, ctrl_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   compare_q, compare_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   capture_q, capture_d;
    logic               wrap_q, wrap_d;
    logic               cap_q, cap_d;
    logic               ovr_q, ovr_d;
    logic               swtrig_q, swtrig_d;
    logic               out_q, out_d;

    logic        en, inv, oneshot;
    mode_e       mode;
    edge_e       edge_sel;
    logic [3:0]  insel;
    logic [15:0] rise_ext, fall_ext;

    logic hw_evt, evt, tick, step, at_top, pwm_level;
    logic set_wrap, set_cap, set_ovr, toggle;

    assign en       = ctrl_q[CTRL_EN];
    assign inv      = ctrl_q[CTRL_INV];
    assign oneshot  = ctrl_q[CTRL_ONESHOT];
    assign mode     = mode_e'(ctrl_q[CTRL_MODE_LSB +: 2]);
    assign edge_sel = edge_e'(ctrl_q[CTRL_EDGE_LSB +: 2]);
    assign insel    = ctrl_q[CTRL_INSEL_LSB +: 4];

    // Zero-extend so any INSEL value indexes safely; lines >= NUM_IN never fire
    assign rise_ext = 16'(rise_i);
    assign fall_ext = 16'(fall_i);

    always_comb begin
        hw_evt = 1'b0;
        case (edge_sel)
            EDGE_RISE: hw_evt = rise_ext[insel];
            EDGE_FALL: hw_evt = fall_ext[insel];
            EDGE_BOTH: hw_evt = rise_ext[insel] | fall_ext[insel];
            default:   hw_evt = 1'b0;
        endcase
    end

    assign evt       = en & (hw_evt | swtrig_q);
    assign tick      = en & (pcnt_q >= presc_q);
    // Event mode counts events directly and bypasses the prescaler
    assign step      = (mode == MODE_EVENT) ? evt : tick;
    // >= so that lowering TARGET below the count wraps on the next step
    assign at_top    = (count_q >= target_q);
    assign pwm_level = (count_q < compare_q) ^ inv;

    always_comb begin
        ctrl_d    = ctrl_q;
        presc_d   = presc_q;
        pcnt_d    = pcnt_q;
        target_d  = target_q;
        compare_d = compare_q;
        count_d   = count_q;
        capture_d = capture_q;
        wrap_d    = wrap_q;
        cap_d     = cap_q;
        ovr_d     = ovr_q;
        swtrig_d  = 1'b0;
        out_d     = out_q;
        set_wrap  = 1'b0;
        set_cap   = 1'b0;
        set_ovr   = 1'b0;
        toggle    = 1'b0;

        if (en && (mode != MODE_EVENT)) begin
            pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        end

        if (step) begin
            if (at_top) begin
                set_wrap = 1'b1;
                toggle   = (mode != MODE_PWM);
                if (oneshot && ((mode == MODE_TIMER) || (mode == MODE_PWM))) begin
                    count_d         = target_q;
                    ctrl_d[CTRL_EN] = 1'b0;
                end else begin
                    count_d = '0;
                end
            end else begin
                count_d = count_q + 1'b1;
            end
        end

        if ((mode == MODE_CAPTURE) && evt) begin
            capture_d = count_q;
            set_cap   = 1'b1;
            set_ovr   = cap_q;
        end

        if (en) begin
            if (mode == MODE_PWM) begin
                out_d = pwm_level;
            end else if (toggle) begin
                out_d = ~out_q;
            end
        end

        // Bus writes are applied after the hardware updates so that CLEAR
        // beats a simultaneous tick and a CTRL write beats the one-shot EN clear
        if (wr_i) begin
            case (reg_i)
                REG_CTRL:    ctrl_d    = wdata_i & CTRL_MASK;
                REG_PRESC:   presc_d   = wdata_i[PRESC_W-1:0];
                REG_TARGET:  target_d  = wdata_i[CNT_W-1:0];
                REG_COMPARE: compare_d = wdata_i[CNT_W-1:0];
                REG_STATUS: begin
                    wrap_d = wrap_q & ~wdata_i[STAT_WRAP];
                    cap_d  = cap_q  & ~wdata_i[STAT_CAP];
                    ovr_d  = ovr_q  & ~wdata_i[STAT_OVR];
                end
                REG_CMD: begin
                    if (wdata_i[CMD_CLEAR]) begin
                        count_d = '0;
                        pcnt_d  = '0;
                    end
                    swtrig_d = wdata_i[CMD_SWTRIG];
                end
                default: ;
            endcase
        end

        // Hardware set wins over a simultaneous write-1-to-clear
        wrap_d = wrap_d | set_wrap;
        cap_d  = cap_d  | set_cap;
        ovr_d  = ovr_d  | set_ovr;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q    <= '0;
            presc_q   <= '0;
            pcnt_q    <= '0;
            target_q  <= '1;
            compare_q <= '0;
            count_q   <= '0;
            capture_q <= '0;
            wrap_q    <= 1'b0;
            cap_q     <= 1'b0;
            ovr_q     <= 1'b0;
            swtrig_q  <= 1'b0;
            out_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
            target_q  <= target_d;
            compare_q <= compare_d;
            count_q   <= count_d;
            capture_q <= capture_d;
            wrap_q    <= wrap_d;
            cap_q     <= cap_d;
            ovr_q     <= ovr_d;
            swtrig_q  <= swtrig_d;
            out_q     <= out_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (reg_i)
            REG_CTRL:    rdata_o = ctrl_q;
            REG_PRESC:   rdata_o = 16'(presc_q);
            REG_TARGET:  rdata_o = 16'(target_q);
            REG_COMPARE: rdata_o = 16'(compare_q);
            REG_COUNT:   rdata_o = 16'(count_q);
            REG_CAPTURE: rdata_o = 16'(capture_q);
            REG_STATUS:  rdata_o = {12'b0, en, ovr_q, cap_q, wrap_q};
            default:     rdata_o = '0;
        endcase
    end

    assign out_o     = out_q;
    assign irq_req_o = (wrap_q & ctrl_q[CTRL_IE_WRAP]) | (cap_q & ctrl_q[CTRL_IE_CAP]);

endmodule

// File: rtl/gp_timer_array.sv
// gp_timer_array
// NUM_CH independent timer channels behind a 16-bit register bus.
// addr_i = {channel, reg[2:0]}; accesses to channel >= NUM_CH read 0 and
// write nothing.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   acc_en_i      bus access strobe; wr_en_i selects write (1) or read (0)
//   addr_i        channel / register select
//   wdata_i       write data
//   input_i       asynchronous external event inputs
//   rdata_o       registered read data, held until the next read
//   out_o         per-channel registered output
//   irq_o         registered OR of all channels' enabled pending flags
module gp_timer_array
    import gp_timer_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int NUM_IN  = 8,
    parameter int PRESC_W = 8,
    parameter int AW      = $clog2(NUM_CH) + 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              acc_en_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [15:0]       wdata_i,
    input  logic [NUM_IN-1:0] input_i,
    output logic [15:0]       rdata_o,
    output logic [NUM_CH-1:0] out_o,
    output logic              irq_o
);

    logic [NUM_IN-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_IN-1:0] rise, fall;

    logic [4:0]  ch_idx;
    logic [2:0]  reg_idx;
    logic        ch_valid;

    logic [NUM_CH-1:0] wr_ch;
    logic [NUM_CH-1:0] irq_req;
    logic [15:0]       ch_rdata [NUM_CH];

    logic [15:0] rdata_q, rdata_d;
    logic        irq_q;

    assign ch_idx   = 5'(addr_i >> 3);
    assign reg_idx  = addr_i[2:0];
    assign ch_valid = (ch_idx < 5'(NUM_CH));

    // Synchronised inputs feed a one-flop edge detector; the pulses are
    // shared by every channel, each picking its own line via INSEL
    assign rise = sync2_q & ~prev_q;
    assign fall = ~sync2_q & prev_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr_ch[g] = acc_en_i & wr_en_i & ch_valid & (ch_idx == 5'(g));

        gp_timer_channel #(
            .CNT_W   (CNT_W),
            .PRESC_W (PRESC_W),
            .NUM_IN  (NUM_IN)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .wr_i      (wr_ch[g]),
            .reg_i     (reg_idx),
            .wdata_i   (wdata_i),
            .rise_i    (rise),
            .fall_i    (fall),
            .rdata_o   (ch_rdata[g]),
            .out_o     (out_o[g]),
            .irq_req_o (irq_req[g])
        );
    end

    always_comb begin
        rdata_d = rdata_q;
        if (acc_en_i && !wr_en_i) begin
            rdata_d = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_idx == 5'(c)) begin
                    rdata_d = ch_rdata[c];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync1_q <= input_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rdata_q <= rdata_d;
            irq_q   <= |irq_req;
        end
    end

    assign rdata_o = rdata_q;
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_gp_timer_array.sv
module tb_gp_timer_array;

    localparam int R_CTRL    = 0;
    localparam int R_PRESC   = 1;
    localparam int R_TARGET  = 2;
    localparam int R_COMPARE = 3;
    localparam int R_COUNT   = 4;
    localparam int R_CAPTURE = 5;
    localparam int R_STATUS  = 6;
    localparam int R_CMD     = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        acc_en;
    logic        wr_en;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  in_sig;
    logic [15:0] rdata;
    logic [3:0]  out_sig;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    gp_timer_array dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .acc_en_i (acc_en),
        .wr_en_i  (wr_en),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .input_i  (in_sig),
        .rdata_o  (rdata),
        .out_o    (out_sig),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input int ch, input int r, input logic [15:0] d);
        acc_en = 1'b1;
        wr_en  = 1'b1;
        addr   = 5'(ch * 8 + r);
        wdata  = d;
        cyc(1);
        acc_en = 1'b0;
        wr_en  = 1'b0;
    endtask

    task automatic bus_rd(input int ch, input int r, output logic [15:0] d);
        acc_en = 1'b1;
        wr_en  = 1'b0;
        addr   = 5'(ch * 8 + r);
        cyc(1);
        acc_en = 1'b0;
        d      = rdata;
    endtask

    task automatic count_high(input int bitn, input int n, output int hi);
        hi = 0;
        repeat (n) begin
            cyc(1);
            if (out_sig[bitn]) hi++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rd;
        int hi;
        int toggles;
        int first_tog;
        logic prev_out;

        rst    = 1'b1;
        acc_en = 1'b0;
        wr_en  = 1'b0;
        addr   = '0;
        wdata  = '0;
        in_sig = '0;
        cyc(2);
        rst = 1'b0;

        // Reset state
        check("rst_rdata", rdata, 16'h0);
        check("rst_out", out_sig, 4'h0);
        check("rst_irq", irq, 1'b0);
        bus_rd(0, R_TARGET, rd);  check("rst_target", rd, 16'hFFFF);
        bus_rd(0, R_CTRL, rd);    check("rst_ctrl", rd, 16'h0000);
        bus_rd(3, R_STATUS, rd);  check("rst_status", rd, 16'h0000);

        // Ch0 periodic timer: PRESC=1, TARGET=4 -> wrap every 10 clocks
        bus_wr(0, R_PRESC, 16'd1);
        bus_wr(0, R_TARGET, 16'd4);
        bus_wr(0, R_CTRL, 16'h0081);          // EN | IE_WRAP
        toggles   = 0;
        first_tog = 0;
        prev_out  = out_sig[0];
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            if (out_sig[0] != prev_out) begin
                toggles++;
                if (first_tog == 0) first_tog = i;
            end
            prev_out = out_sig[0];
        end
        check("t0_first_toggle", first_tog, 10);
        check("t0_toggles", toggles, 4);
        bus_rd(0, R_STATUS, rd);  check("t0_status_wrap", rd, 16'h0009);
        check("t0_irq_high", irq, 1'b1);
        bus_wr(0, R_STATUS, 16'h0001);
        check("t0_irq_still_high", irq, 1'b1);
        cyc(1);
        check("t0_irq_fell", irq, 1'b0);
        bus_rd(0, R_STATUS, rd);  check("t0_status_w1c", rd, 16'h0008);
        bus_wr(0, R_CTRL, 16'h0000);

        // Ch1 PWM: TARGET=9, COMPARE=3
        bus_wr(1, R_TARGET, 16'd9);
        bus_wr(1, R_COMPARE, 16'd3);
        bus_wr(1, R_CTRL, 16'h0003);          // EN | MODE=PWM
        cyc(20);
        count_high(1, 20, hi);    check("t1_pwm_duty", hi, 6);
        bus_wr(1, R_CTRL, 16'h000B);          // + INV
        cyc(5);
        count_high(1, 20, hi);    check("t1_pwm_inv", hi, 14);
        bus_wr(1, R_COMPARE, 16'd0);
        bus_wr(1, R_CTRL, 16'h0003);
        cyc(3);
        count_high(1, 20, hi);    check("t1_pwm_cmp0", hi, 0);
        bus_wr(1, R_COMPARE, 16'd12);
        cyc(3);
        count_high(1, 20, hi);    check("t1_pwm_cmp_gt_tgt", hi, 20);

        // Ch2 event counter on input 5, both edges
        bus_wr(2, R_CTRL, 16'h5065);          // EN | EVENT | EDGE=both | INSEL=5
        for (int i = 0; i < 6; i++) begin
            in_sig[5] = ~in_sig[5];
            cyc(4);
        end
        cyc(4);
        bus_rd(2, R_COUNT, rd);   check("t2_count6", rd, 16'd6);
        bus_wr(2, R_TARGET, 16'd3);
        for (int i = 0; i < 6; i++) begin
            in_sig[5] = ~in_sig[5];
            cyc(4);
        end
        cyc(4);
        bus_rd(2, R_COUNT, rd);   check("t2_count_wrapped", rd, 16'd1);
        bus_rd(2, R_STATUS, rd);  check("t2_status", rd, 16'h0009);
        bus_wr(2, R_CMD, 16'h0002);           // SW_TRIG
        cyc(1);
        bus_rd(2, R_COUNT, rd);   check("t2_swtrig", rd, 16'd2);

        // Ch3 capture on rising edge of input 3
        bus_wr(3, R_CTRL, 16'h3127);          // EN | CAPTURE | EDGE=rise | IE_CAP | INSEL=3
        cyc(18);
        in_sig[3] = 1'b1;
        cyc(4);
        in_sig[3] = 1'b0;
        bus_rd(3, R_CAPTURE, rd); check("t3_capture1", rd, 16'd20);
        bus_rd(3, R_STATUS, rd);  check("t3_status_cap", rd, 16'h000A);
        cyc(8);
        in_sig[3] = 1'b1;
        cyc(5);
        in_sig[3] = 1'b0;
        bus_rd(3, R_CAPTURE, rd); check("t3_capture2", rd, 16'd34);
        bus_rd(3, R_STATUS, rd);  check("t3_status_ovr", rd, 16'h000E);
        check("t3_irq", irq, 1'b1);
        bus_wr(3, R_STATUS, 16'h0006);
        cyc(1);
        check("t3_irq_cleared", irq, 1'b0);
        bus_rd(3, R_STATUS, rd);  check("t3_status_w1c", rd, 16'h0008);

        // Ch0 one-shot, TARGET=5
        bus_wr(0, R_PRESC, 16'd0);
        bus_wr(0, R_TARGET, 16'd5);
        bus_wr(0, R_CMD, 16'h0001);
        bus_wr(0, R_CTRL, 16'h0011);          // EN | ONESHOT
        cyc(15);
        bus_rd(0, R_COUNT, rd);   check("t4_oneshot_count", rd, 16'd5);
        bus_rd(0, R_CTRL, rd);    check("t4_oneshot_ctrl", rd, 16'h0010);
        bus_rd(0, R_STATUS, rd);  check("t4_oneshot_status", rd, 16'h0001);
        bus_wr(0, R_CTRL, 16'h0001);          // free-running, ticks every clock
        cyc(3);
        bus_wr(0, R_CMD, 16'h0001);           // CLEAR on a tick edge
        bus_rd(0, R_COUNT, rd);   check("t4_clear_wins", rd, 16'd0);
        bus_wr(0, R_CTRL, 16'h0000);

        // Mid-run reset
        check("t5_pre_out1", out_sig[1], 1'b1);
        bus_rd(1, R_TARGET, rd);  check("t5_pre_target", rd, 16'd9);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("t5_rdata", rdata, 16'h0);
        check("t5_out", out_sig, 4'h0);
        check("t5_irq", irq, 1'b0);
        bus_rd(1, R_TARGET, rd);  check("t5_target", rd, 16'hFFFF);
        bus_rd(1, R_COMPARE, rd); check("t5_compare", rd, 16'h0000);
        bus_rd(3, R_CAPTURE, rd); check("t5_capture", rd, 16'h0000);
        bus_rd(2, R_COUNT, rd);   check("t5_count", rd, 16'h0000);
        bus_rd(3, R_CTRL, rd);    check("t5_ctrl", rd, 16'h0000);
        bus_rd(0, R_STATUS, rd);  check("t5_status", rd, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
